spi_port_arbiter: RTL

- Round-robin arbiter that shares one router output path (the SPI transmit stage) among N_REQ input ports.
- Each port raises a request level. The arbiter grants one port at a time and holds the grant until that port signals end-of-packet, drops its request, or exceeds a hold-time watchdog.
- A port that times out is masked until it deasserts its request, so a stuck port cannot monopolise the output.

---
 rtl/spi_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spi_port_arbiter.sv
// Round-robin arbiter sharing the SPI transmit path among N_REQ ports.
// A grant ends on end-of-packet, request drop, or hold-time watchdog; timed-out ports stay masked until they drop req.
//
// state | meaning
// IDLE  | no grant active, searching from ptr+1 for the next effective request
// GRANT | one port owns the output; hold counter running
module spi_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] eop,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout,
    output logic [N_REQ-1:0] masked
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [N_REQ-1:0] masked_q, masked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] eff;
    logic             found;
    logic [IDX_W-1:0] win;
    logic             own_eop;
    logic             own_req;

    always_comb begin
        eff   = req & ~masked_q;
        found = 1'b0;
        win   = '0;
        // Scan ptr+1, ptr+2, ... so the last owner is considered last.
        for (int off = 1; off <= N_REQ; off++) begin
            int idx;
            idx = (int'(ptr_q) + off) % N_REQ;
            if (!found && eff[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    assign own_eop = eop[grant_idx_q];
    assign own_req = req[grant_idx_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        // A port's lockout lifts the first cycle it lets go of its request.
        masked_d    = masked_q & req;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    grant_d     = '0;
                    grant_d[win] = 1'b1;
                    grant_idx_d = win;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_W'(1);
                end
            end
            GRANT: begin
                if (own_eop || !own_req || cnt_q == HOLD_MAX) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = grant_idx_q;
                    if (!own_eop && own_req) begin
                        timeout_d              = 1'b1;
                        masked_d[grant_idx_q]  = 1'b1;
                    end
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            masked_q    <= '0;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            masked_q    <= masked_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;
    assign masked    = masked_q;

endmodule
